exec_sched: RTL and testbench

//   Sequences cpu_core from the three debounced button pulses. Issues load/start requests, gates

---
 rtl/exec_sched.sv | 157 +++++++++++++++
 tb/tb_exec_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/exec_sched.sv
// Run/step scheduler for cpu_core: turns debounced button pulses into load/start requests and a gated step enable.
// Optional STEP_COUNT_EN macro builds a saturating step counter; otherwise step_count is tied to zero.
module exec_sched #(
  parameter int DIV_WIDTH = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 run_pulse,
  input  logic                 mode_pulse,
  input  logic                 load_pulse,
  input  logic                 core_loaded,
  input  logic                 core_exec,
  output logic                 start_req,
  output logic                 load_req,
  output logic                 step_en,
  output logic [1:0]           mode,
  output logic [2:0]           sched_state,
  output logic [CNT_WIDTH-1:0] step_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] M_FAST   = 2'b00;
  localparam logic [1:0] M_SLOW   = 2'b01;
  localparam logic [1:0] M_SINGLE = 2'b10;

  state_t               state_r;
  state_t               state_s;
  logic [1:0]           mode_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic                 seen_exec_r;
  logic                 start_s;
  logic                 load_s;
  logic                 step_s;
  logic                 entry_s;
  logic                 stay_run_s;

  // State and registered control outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      start_req <= 1'b0;
      load_req  <= 1'b0;
      step_en   <= 1'b0;
    end else begin
      state_r   <= state_s;
      start_req <= start_s;
      load_req  <= load_s;
      step_en   <= step_s;
    end
  end

  // Next-state decision; load_pulse always outranks run_pulse.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (load_pulse) state_s = S_LOAD;
        else if (run_pulse && core_loaded) state_s = S_ARMED;
        else state_s = S_IDLE;
      end
      S_LOAD: begin
        if (core_loaded) state_s = S_ARMED;
        else state_s = S_LOAD;
      end
      S_ARMED, S_PAUSE, S_DONE: begin
        if (load_pulse) state_s = S_LOAD;
        else if (run_pulse) state_s = S_RUN;
        else state_s = state_r;
      end
      S_RUN: begin
        if (load_pulse) state_s = S_LOAD;
        else if (seen_exec_r && !core_exec) state_s = S_DONE;
        else if (run_pulse && (mode_r != M_SINGLE)) state_s = S_PAUSE;
        else state_s = S_RUN;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; a step is only granted while RUN continues.
  always_comb begin
    load_s     = (state_s == S_LOAD) && (state_r != S_LOAD);
    start_s    = (state_s == S_RUN) && ((state_r == S_ARMED) || (state_r == S_DONE));
    entry_s    = (state_s == S_RUN) && (state_r != S_RUN);
    stay_run_s = (state_s == S_RUN) && (state_r == S_RUN);
    step_s     = 1'b0;
    if (stay_run_s) begin
      case (mode_r)
        M_FAST:   step_s = 1'b1;
        M_SLOW:   step_s = (div_r == {DIV_WIDTH{1'b1}});
        M_SINGLE: step_s = run_pulse;
        default:  step_s = 1'b0;
      endcase
    end else begin
      step_s = 1'b0;
    end
  end

  // Run mode, slow divider and the "core has started executing" flag.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      mode_r      <= M_FAST;
      div_r       <= {DIV_WIDTH{1'b0}};
      seen_exec_r <= 1'b0;
    end else begin
      if (mode_pulse) begin
        case (mode_r)
          M_FAST:  mode_r <= M_SLOW;
          M_SLOW:  mode_r <= M_SINGLE;
          default: mode_r <= M_FAST;
        endcase
      end
      if (mode_pulse || entry_s) begin
        div_r <= {DIV_WIDTH{1'b0}};
      end else if (stay_run_s && (mode_r == M_SLOW)) begin
        div_r <= div_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
      if (entry_s) begin
        seen_exec_r <= 1'b0;
      end else if ((state_r == S_RUN) && core_exec) begin
        seen_exec_r <= 1'b1;
      end
    end
  end

  assign mode        = mode_r;
  assign sched_state = state_r;

`ifdef STEP_COUNT_EN
  logic [CNT_WIDTH-1:0] step_count_r;

  // Steps since the last start, saturating at all-ones.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      step_count_r <= {CNT_WIDTH{1'b0}};
    end else if (start_s) begin
      step_count_r <= {CNT_WIDTH{1'b0}};
    end else if (step_en && (step_count_r != {CNT_WIDTH{1'b1}})) begin
      step_count_r <= step_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign step_count = step_count_r;
`else
  assign step_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_exec_sched.sv
// Bench for exec_sched: table of per-cycle vectors plus hand sequences for SLOW, SINGLE and reset-in-RUN.
module tb_exec_sched;

  localparam int DW = 3;
  localparam int CW = 16;

  logic          CLK;
  logic          resetn;
  logic          run_pulse;
  logic          mode_pulse;
  logic          load_pulse;
  logic          core_loaded;
  logic          core_exec;
  logic          start_req;
  logic          load_req;
  logic          step_en;
  logic [1:0]    mode;
  logic [2:0]    sched_state;
  logic [CW-1:0] step_count;

  typedef struct packed {
    logic       run;
    logic       modep;
    logic       load;
    logic       loaded;
    logic       exec;
    logic       e_start;
    logic       e_lreq;
    logic       e_step;
    logic [1:0] e_mode;
    logic [2:0] e_state;
  } vec_t;

  logic [7:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  exec_sched #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .resetn(resetn), .run_pulse(run_pulse), .mode_pulse(mode_pulse),
    .load_pulse(load_pulse), .core_loaded(core_loaded), .core_exec(core_exec),
    .start_req(start_req), .load_req(load_req), .step_en(step_en), .mode(mode),
    .sched_state(sched_state), .step_count(step_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t v(input logic r, input logic m, input logic l, input logic ld,
                             input logic ex, input logic st, input logic lq, input logic se,
                             input logic [1:0] md, input logic [2:0] ss);
    vec_t t;
    t = '{run: r, modep: m, load: l, loaded: ld, exec: ex,
          e_start: st, e_lreq: lq, e_step: se, e_mode: md, e_state: ss};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, compare them.
  task automatic apply(input vec_t t, input string name);
    run_pulse   = t.run;
    mode_pulse  = t.modep;
    load_pulse  = t.load;
    core_loaded = t.loaded;
    core_exec   = t.exec;
    exp_q.push_back({t.e_start, t.e_lreq, t.e_step, t.e_mode, t.e_state});
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_empty"}, 32'd1, 32'd0);
    end else begin
      check(name, {24'd0, start_req, load_req, step_en, mode, sched_state}, {24'd0, exp_q.pop_front()});
    end
  endtask

  vec_t tbl[28];

  initial begin
    logic [CW-1:0] exp_cnt;
    // inputs: run modep load loaded exec | start lreq step mode state
    tbl[0]  = v(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd0);
    tbl[1]  = v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);
    tbl[2]  = v(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,2'd0,3'd1);
    tbl[3]  = v(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd1);
    tbl[4]  = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);
    tbl[5]  = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);
    tbl[6]  = v(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,2'd0,3'd1);
    tbl[7]  = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);
    tbl[8]  = v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,2'd0,3'd3);
    tbl[9]  = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd0,3'd3);
    tbl[10] = v(1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,2'd0,3'd3);
    tbl[11] = v(1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,2'd0,3'd3);
    tbl[12] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd5);
    tbl[13] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd5);
    tbl[14] = v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,2'd0,3'd3);
    tbl[15] = v(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,2'd0,3'd1);
    tbl[16] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);
    tbl[17] = v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd1,3'd2);
    tbl[18] = v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd2,3'd2);
    tbl[19] = v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);
    tbl[20] = v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,2'd0,3'd3);
    tbl[21] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd0,3'd3);
    tbl[22] = v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd4);
    tbl[23] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd4);
    tbl[24] = v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd3);
    tbl[25] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd0,3'd3);
    tbl[26] = v(1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,2'd0,3'd1);
    tbl[27] = v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd2);

    run_pulse = 1'b0; mode_pulse = 1'b0; load_pulse = 1'b0;
    core_loaded = 1'b0; core_exec = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("reset_outputs", {8'd0, start_req, load_req, step_en, mode, sched_state, step_count}, 32'd0);
    @(posedge CLK);
    #1 resetn = 1'b1;

    for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // SLOW with an 8-cycle divider: one step per 8 cycles, then pause stops stepping.
    apply(v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd1,3'd2), "slow_mode");
    apply(v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,2'd1,3'd3), "slow_start");
    for (int i = 1; i <= 32; i++)
      apply(v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,((i % 8) == 0),2'd1,3'd3), $sformatf("slow_run%0d", i));
    apply(v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd1,3'd4), "slow_pause");
    for (int i = 0; i < 10; i++)
      apply(v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd1,3'd4), $sformatf("slow_paused%0d", i));

    // SINGLE: reload, select SINGLE, start, then three step pulses.
    apply(v(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,2'd1,3'd1), "single_load");
    apply(v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd1,3'd2), "single_armed");
    apply(v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd2,3'd2), "single_mode");
    apply(v(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,2'd2,3'd3), "single_start");
    check("count_cleared", {16'd0, step_count}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'b0010_1001;
      apply(v(pat[i],1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,pat[i],2'd2,3'd3), $sformatf("single_step%0d", i));
    end
`ifdef STEP_COUNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    check("step_count", {16'd0, step_count}, {16'd0, exp_cnt});

    // Into SLOW while running, then reset asynchronously mid-cycle.
    apply(v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd3), "rst_mode_fast");
    apply(v(1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,2'd1,3'd3), "rst_mode_slow");
    for (int i = 0; i < 3; i++)
      apply(v(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,2'd1,3'd3), $sformatf("rst_slow%0d", i));
    #2 resetn = 1'b0;
    #1;
    check("async_reset", {8'd0, start_req, load_req, step_en, mode, sched_state, step_count}, 32'd0);
    load_pulse = 1'b1;
    @(posedge CLK);
    #1;
    check("held_reset", {8'd0, start_req, load_req, step_en, mode, sched_state, step_count}, 32'd0);
    load_pulse = 1'b0;
    resetn = 1'b1;
    apply(v(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,2'd0,3'd0), "post_reset");

    run_pulse = 1'b0; mode_pulse = 1'b0; load_pulse = 1'b0;
    core_loaded = 1'b0; core_exec = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
